// File: rtl/max_subtract_64.sv
// max_subtract_64: subtracts the per-segment max from every lane in a 2-stage enabled pipeline
module max_subtract_64 #(
  parameter int DW = 16,
  parameter int N  = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [3:0]        i_length_mode,
  input  logic [N-1:0]      i_valid,
  input  logic [N*DW-1:0]   i_in_flat,
  input  logic [DW-1:0]     i_max64_0,
  input  logic [DW-1:0]     i_max32_0,
  input  logic [DW-1:0]     i_max32_1,
  input  logic [DW-1:0]     i_max16_0,
  input  logic [DW-1:0]     i_max16_1,
  input  logic [DW-1:0]     i_max16_2,
  input  logic [DW-1:0]     i_max16_3,
  output logic [N-1:0]      o_valid,
  output logic [N*DW-1:0]   o_diff_flat,
  output logic [3:0]        o_length_mode,
  output logic              o_err_mode,
  output logic [15:0]       o_frame_cnt
);
  logic                  legal;
  logic [1:0][DW-1:0]    max32;
  logic [3:0][DW-1:0]    max16;
  logic [N*DW-1:0]       x1_d, x1_q;
  logic [N-1:0][DW-1:0]  m1_d, m1_q;
  logic [N-1:0]          v1_d, v1_q;
  logic [3:0]            lm1_d, lm1_q;
  logic                  err_d, err_q;
  logic [N*DW-1:0]       diff_d, diff_q;
  logic [N-1:0]          valid_d, valid_q;
  logic [3:0]            lm2_d, lm2_q;
  logic [15:0]           cnt_d, cnt_q;
  logic [DW:0]           d;
  logic [DW-1:0]         x, m;
  assign max32 = {i_max32_1, i_max32_0};
  assign max16 = {i_max16_3, i_max16_2, i_max16_1, i_max16_0};
  // Stage 1: decode the mode, pick each lane's segment max and latch the lane data
  always_comb begin
    legal = (i_length_mode == 4'b0100) | (i_length_mode == 4'b0010) | (i_length_mode == 4'b0001);
    x1_d  = i_en ? i_in_flat : x1_q;
    lm1_d = i_en ? i_length_mode : lm1_q;
    v1_d  = i_en ? (i_valid & {N{legal}}) : v1_q;
    err_d = err_q | (i_en & ~legal);
    m1_d  = m1_q;
    for (int k = 0; k < N; k++)
      m1_d[k] = !i_en ? m1_q[k] :
                i_length_mode[1] ? max32[k[5]] :
                i_length_mode[0] ? max16[k[5:4]] : i_max64_0;
  end
  // Stage 2: 17-bit subtract, saturate to 16 bits, and force invalid lanes to the most negative code
  always_comb begin
    diff_d = diff_q;
    d = '0;
    x = '0;
    m = '0;
    for (int k = 0; k < N; k++) begin
      x = x1_q[k*DW +: DW];
      m = m1_q[k];
      d = {x[DW-1], x} - {m[DW-1], m};
      if (i_en)
        diff_d[k*DW +: DW] = !v1_q[k] ? {1'b1, {(DW-1){1'b0}}} :
                             (d[DW] != d[DW-1]) ? {d[DW], {(DW-1){~d[DW]}}} : d[DW-1:0];
    end
    valid_d = i_en ? v1_q : valid_q;
    lm2_d   = i_en ? lm1_q : lm2_q;
    cnt_d   = cnt_q + {15'd0, i_en & (|v1_q)};
  end
  // Pipeline, flag and counter registers with asynchronous clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x1_q    <= '0;
      m1_q    <= '0;
      v1_q    <= '0;
      lm1_q   <= '0;
      err_q   <= 1'b0;
      diff_q  <= '0;
      valid_q <= '0;
      lm2_q   <= '0;
      cnt_q   <= '0;
    end else begin
      x1_q    <= x1_d;
      m1_q    <= m1_d;
      v1_q    <= v1_d;
      lm1_q   <= lm1_d;
      err_q   <= err_d;
      diff_q  <= diff_d;
      valid_q <= valid_d;
      lm2_q   <= lm2_d;
      cnt_q   <= cnt_d;
    end
  end
  assign o_valid       = valid_q;
  assign o_diff_flat   = diff_q;
  assign o_length_mode = lm2_q;
  assign o_err_mode    = err_q;
  assign o_frame_cnt   = cnt_q;
endmodule

// File: tb/tb_max_subtract_64.sv
// tb_max_subtract_64: random and directed stimulus against a frame-level reference model
module tb_max_subtract_64;
  logic          clk = 0, rst = 1, en = 0;
  logic [3:0]    mode = 0;
  logic [63:0]   valid = 0;
  logic [1023:0] x = 0;
  logic [15:0]   mx64 = 0;
  logic [15:0]   mx32 [2];
  logic [15:0]   mx16 [4];
  logic [63:0]   o_valid;
  logic [1023:0] o_diff_flat;
  logic [3:0]    o_length_mode;
  logic          o_err_mode;
  logic [15:0]   o_frame_cnt;
  int errors = 0, checks = 0;
  typedef struct {
    logic [1023:0] d;
    logic [63:0]   v;
    logic [3:0]    lm;
  } frame_t;
  frame_t q[$];
  frame_t cur;
  logic        err_m;
  logic [15:0] cnt_m;
  max_subtract_64 dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_length_mode(mode), .i_valid(valid),
    .i_in_flat(x), .i_max64_0(mx64), .i_max32_0(mx32[0]), .i_max32_1(mx32[1]),
    .i_max16_0(mx16[0]), .i_max16_1(mx16[1]), .i_max16_2(mx16[2]), .i_max16_3(mx16[3]),
    .o_valid(o_valid), .o_diff_flat(o_diff_flat), .o_length_mode(o_length_mode),
    .o_err_mode(o_err_mode), .o_frame_cnt(o_frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit is_legal(input logic [3:0] md);
    return md == 4'b0100 || md == 4'b0010 || md == 4'b0001;
  endfunction
  function automatic frame_t model();
    frame_t f;
    int xi, mi, dd;
    logic [15:0] mv;
    f.lm = mode;
    for (int k = 0; k < 64; k++) begin
      mv = mode == 4'b0010 ? mx32[k/32] : mode == 4'b0001 ? mx16[k/16] : mx64;
      xi = $signed(x[k*16 +: 16]);
      mi = $signed(mv);
      dd = xi - mi;
      if (dd > 32767) dd = 32767;
      if (dd < -32768) dd = -32768;
      f.v[k] = is_legal(mode) && valid[k];
      f.d[k*16 +: 16] = f.v[k] ? dd[15:0] : 16'h8000;
    end
    return f;
  endfunction
  task automatic model_reset();
    frame_t b;
    b.d = {64{16'h8000}};
    b.v = '0;
    b.lm = '0;
    q.delete();
    q.push_back(b);
    cur.d = '0;
    cur.v = '0;
    cur.lm = '0;
    err_m = 0;
    cnt_m = 0;
  endtask
  task automatic compare_all();
    for (int k = 0; k < 64; k++)
      chk($sformatf("lane%0d", k), 64'(o_diff_flat[k*16 +: 16]), 64'(cur.d[k*16 +: 16]));
    chk("valid", o_valid, cur.v);
    chk("length_mode", 64'(o_length_mode), 64'(cur.lm));
    chk("err_mode", 64'(o_err_mode), 64'(err_m));
    chk("frame_cnt", 64'(o_frame_cnt), 64'(cnt_m));
  endtask
  task automatic step();
    @(posedge clk);
    if (en) begin
      cur = q.pop_front();
      q.push_back(model());
      if (!is_legal(mode)) err_m = 1;
      if (|cur.v) cnt_m++;
    end
    #1 compare_all();
  endtask
  task automatic do_reset();
    #2 rst = 1;
    #1 model_reset();
    compare_all();
    @(negedge clk) rst = 0;
  endtask
  initial begin
    mx32 = '{default: 0};
    mx16 = '{default: 0};
    model_reset();
    #12 compare_all();
    @(negedge clk) rst = 0;
    en = 1;
    mode = 4'b0100; valid = '1; mx64 = 16'd63;
    for (int k = 0; k < 64; k++) x[k*16 +: 16] = 16'(k);
    step();
    valid = '0;
    step();
    chk("t64_lane5", 64'(o_diff_flat[5*16 +: 16]), 64'(16'hffc6));
    chk("t64_valid", o_valid, '1);
    chk("t64_cnt", 64'(o_frame_cnt), 1);
    mode = 4'b0001; valid = '1; mx16 = '{16'd10, 16'd20, 16'd30, 16'd40};
    for (int k = 0; k < 64; k++) x[k*16 +: 16] = 16'd5;
    step();
    valid = '0;
    step();
    chk("t16_lane40", 64'(o_diff_flat[40*16 +: 16]), 64'(16'hffe7));
    mode = 4'b0010; valid = '1; mx32 = '{16'h7fff, 16'h8000};
    for (int k = 0; k < 64; k++) x[k*16 +: 16] = k < 32 ? 16'h8000 : 16'h7fff;
    step();
    valid = '0;
    step();
    chk("t32_sat_lo", 64'(o_diff_flat[3*16 +: 16]), 64'(16'h8000));
    chk("t32_sat_hi", 64'(o_diff_flat[50*16 +: 16]), 64'(16'h7fff));
    mode = 4'b0011; valid = '1;
    step();
    chk("err_set", 64'(o_err_mode), 1);
    mode = 4'b0100;
    step();
    chk("err_lanes_valid", o_valid, 0);
    step();
    chk("err_sticky", 64'(o_err_mode), 1);
    do_reset();
    mode = 4'b0100; valid = '1; mx64 = 16'd100;
    for (int k = 0; k < 64; k++) x[k*16 +: 16] = 16'(k * 3);
    step();
    en = 0;
    step();
    en = 1;
    step();
    step();
    valid = '0;
    step();
    step();
    step();
    chk("stall_cnt", 64'(o_frame_cnt), 3);
    step();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 7);
      mode = r < 2 ? 4'b0100 : r < 4 ? 4'b0010 : r < 6 ? 4'b0001 : 4'($urandom);
      valid = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) valid = '1;
      for (int k = 0; k < 64; k++)
        x[k*16 +: 16] = r[0] ? 16'($urandom) : 16'($urandom_range(0, 200) - 100);
      mx64 = 16'($urandom);
      for (int k = 0; k < 2; k++) mx32[k] = 16'($urandom);
      for (int k = 0; k < 4; k++) mx16[k] = 16'($urandom);
      en = $urandom_range(0, 4) != 0;
      step();
      if (i == 150) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
